// File: rtl/lpc_pkg.sv
// Shared LPC definitions: host FSM states, CYCTYPE/DIR nibbles, SYNC codes and
// the latched I/O request payload. The LPC decoder uses the same package.
package lpc_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef logic [NIB_W-1:0] nibble_t;

  localparam nibble_t LAD_START    = 4'b0000;
  localparam nibble_t LAD_IDLE     = 4'b1111;

  localparam nibble_t CYC_IO_READ  = 4'b0000;
  localparam nibble_t CYC_IO_WRITE = 4'b0010;

  localparam nibble_t SYNC_READY      = 4'b0000;
  localparam nibble_t SYNC_SHORT_WAIT = 4'b0101;
  localparam nibble_t SYNC_LONG_WAIT  = 4'b0110;
  localparam nibble_t SYNC_ERROR      = 4'b1010;
  localparam nibble_t SYNC_NONE       = 4'b1111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CYCDIR,
    ST_ADDR,
    ST_WDATA,
    ST_TAR1,
    ST_TAR2,
    ST_SYNC,
    ST_RDATA,
    ST_TAREND1,
    ST_TAREND2,
    ST_ABORT,
    ST_ABORT_REL
  } lpc_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lpc_req_t;

  // Address nibble in bus order: idx 0 is addr[15:12], idx 3 is addr[3:0]
  function automatic nibble_t addr_nibble(input logic [ADDR_W-1:0] addr,
                                          input logic [1:0]        idx);
    nibble_t nib;
    case (idx)
      2'd0:    nib = addr[15:12];
      2'd1:    nib = addr[11:8];
      2'd2:    nib = addr[7:4];
      default: nib = addr[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/lpc_host_io_if.sv
// Request/response handshake and LAD/LFRAME# pins of the LPC I/O host.
// slave: the host block itself; master: the requester / board side.
interface lpc_host_io_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_error;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
    output req_ready, resp_valid, resp_rdata, resp_error,
           lpc_frame, lpc_ad_out, lpc_ad_oe
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           lpc_frame, lpc_ad_out, lpc_ad_oe
  );

endinterface

// File: rtl/lpc_host_io.sv
// LPC host for single-byte I/O read/write cycles with SYNC wait, error and
// no-target handling. Define LPC_HOST_ABORT_EN to signal an LFRAME# abort on timeout.
module lpc_host_io
  import lpc_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 255,
  parameter int unsigned NOSYNC_LIMIT = 3
) (
  input  logic          lpc_clock,
  input  logic          lpc_reset,
  lpc_host_io_if.slave  bus
);

  localparam int unsigned WAIT_W = (SYNC_TIMEOUT > 0) ? $clog2(SYNC_TIMEOUT + 1) : 1;
  localparam int unsigned NS_W   = (NOSYNC_LIMIT > 0) ? $clog2(NOSYNC_LIMIT + 1) : 1;
  localparam int unsigned CNT_W  = 2;

  lpc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [NS_W-1:0]    nosync_q, nosync_d;
  lpc_req_t           req_q, req_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               ready_q, ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_error_q, resp_error_d;
  logic               frame_q, frame_d;
  nibble_t            ad_out_q, ad_out_d;
  logic               ad_oe_q, ad_oe_d;

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wait_q       <= '0;
      nosync_q     <= '0;
      req_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      frame_q      <= 1'b1;
      ad_out_q     <= LAD_IDLE;
      ad_oe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      nosync_q     <= nosync_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      frame_q      <= frame_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
    end
  end

  // Next state; pin values are decoded from the next state so they register in step
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    nosync_d = nosync_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          req_d.write = bus.req_write;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          rdata_d     = '0;
          err_d       = 1'b0;
          state_d     = ST_START;
        end
      end
      ST_START:  state_d = ST_CYCDIR;
      ST_CYCDIR: begin
        cnt_d   = '0;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (cnt_q == CNT_W'(3)) begin
          cnt_d   = '0;
          state_d = req_q.write ? ST_WDATA : ST_TAR1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WDATA: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_TAR1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TAR1: state_d = ST_TAR2;
      ST_TAR2: begin
        wait_d   = '0;
        nosync_d = '0;
        state_d  = ST_SYNC;
      end
      ST_SYNC: begin
        // No-target count only tracks consecutive 1111 samples
        nosync_d = '0;
        case (bus.lpc_ad_in)
          SYNC_READY: begin
            cnt_d   = '0;
            state_d = req_q.write ? ST_TAREND1 : ST_RDATA;
          end
          SYNC_SHORT_WAIT, SYNC_LONG_WAIT: begin
            if (wait_q >= WAIT_W'(SYNC_TIMEOUT)) begin
              err_d   = 1'b1;
              rdata_d = '1;
              cnt_d   = '0;
`ifdef LPC_HOST_ABORT_EN
              state_d = ST_ABORT;
`else
              state_d = ST_TAREND2;
`endif
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
          SYNC_NONE: begin
            if (nosync_q >= NS_W'(NOSYNC_LIMIT)) begin
              err_d   = 1'b1;
              rdata_d = '1;
              cnt_d   = '0;
`ifdef LPC_HOST_ABORT_EN
              state_d = ST_ABORT;
`else
              state_d = ST_TAREND2;
`endif
            end else begin
              nosync_d = nosync_q + NS_W'(1);
            end
          end
          default: begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = req_q.write ? ST_TAREND1 : ST_RDATA;
          end
        endcase
      end
      ST_RDATA: begin
        if (cnt_q == CNT_W'(0)) begin
          rdata_d[3:0] = bus.lpc_ad_in;
          cnt_d        = CNT_W'(1);
        end else begin
          rdata_d[7:4] = bus.lpc_ad_in;
          cnt_d        = '0;
          state_d      = ST_TAREND1;
        end
      end
      ST_TAREND1: state_d = ST_TAREND2;
      ST_TAREND2: state_d = ST_IDLE;
`ifdef LPC_HOST_ABORT_EN
      ST_ABORT: begin
        if (cnt_q == CNT_W'(3)) begin
          cnt_d   = '0;
          state_d = ST_ABORT_REL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ABORT_REL: state_d = ST_TAREND2;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered pin decode for the state being entered
  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_TAREND2);
    resp_error_d = (state_d == ST_TAREND2) && err_d;
    frame_d      = !(state_d inside {ST_START, ST_ABORT});
    ad_oe_d      = state_d inside {ST_START, ST_CYCDIR, ST_ADDR, ST_WDATA,
                                   ST_TAR1, ST_ABORT};
    ad_out_d     = LAD_IDLE;
    case (state_d)
      ST_START:  ad_out_d = LAD_START;
      ST_CYCDIR: ad_out_d = req_d.write ? CYC_IO_WRITE : CYC_IO_READ;
      ST_ADDR:   ad_out_d = addr_nibble(req_d.addr, cnt_d);
      ST_WDATA:  ad_out_d = (cnt_d == CNT_W'(0)) ? req_d.wdata[3:0] : req_d.wdata[7:4];
      default:   ad_out_d = LAD_IDLE;
    endcase
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = resp_error_q;
  assign bus.lpc_frame  = frame_q;
  assign bus.lpc_ad_out = ad_out_q;
  assign bus.lpc_ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_lpc_host_io.sv
// Self-checking bench for lpc_host_io: a per-clock target model drives LAD and
// checks the host drive phase; a scoreboard checks every response pulse.
module tb_lpc_host_io;

  localparam int SYNC_TIMEOUT = 255;
  localparam int NOSYNC_LIMIT = 3;
`ifdef LPC_HOST_ABORT_EN
  localparam int ABORT_EXTRA = 5;
`else
  localparam int ABORT_EXTRA = 0;
`endif

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       chk_rd;
    int         c0;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  lpc_host_io_if bus ();

  lpc_host_io dut (
    .lpc_clock (clk),
    .lpc_reset (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      check_eq("resp_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("resp_latency", 32'(cyc - e.c0), 32'(e.lat));
        check_eq("resp_error", 32'(bus.resp_error), 32'(e.err));
        if (e.chk_rd) check_eq("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus.req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    check_eq("req_ready_wait", 32'(ok), 32'd1);
  endtask

  task automatic check_pins(input string tag, input logic frame, input logic oe, input logic [3:0] ad);
    check_eq({tag, "_frame"}, 32'(bus.lpc_frame), 32'(frame));
    check_eq({tag, "_oe"}, 32'(bus.lpc_ad_oe), 32'(oe));
    check_eq({tag, "_ad"}, 32'(bus.lpc_ad_out), 32'(ad));
  endtask

  // fin: final SYNC nibble after n_wait clocks of wait_nib; fin F = no target, fin 6 = timeout
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                         input int n_wait, input logic [3:0] wait_nib,
                         input logic [3:0] fin, input logic [7:0] rd);
    logic [3:0] nib [10];
    int   n;
    int   sync_start;
    int   n_abort;
    bit   ok;
    bit   aborting;
    exp_t e;

    wait_ready(ok);
    if (!ok) return;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;

    sync_start = wr ? 11 : 9;
    aborting   = (fin == 4'hF) || (fin == 4'h6);
    n_abort    = (fin == 4'hF) ? NOSYNC_LIMIT + 1 : SYNC_TIMEOUT + 1;
    e.c0       = cyc;
    e.chk_rd   = !wr || aborting;
    if (aborting) begin
      e.err   = 1'b1;
      e.rdata = 8'hFF;
      e.lat   = sync_start + n_abort + ABORT_EXTRA;
    end else begin
      e.err   = (fin != 4'h0);
      e.rdata = rd;
      e.lat   = 13 + n_wait;
    end
    exp_q.push_back(e);

    @(negedge clk);
    bus.req_valid = 1'b0;

    n = 0;
    nib[n++] = 4'h0;
    nib[n++] = wr ? 4'h2 : 4'h0;
    for (int k = 0; k < 4; k++) nib[n++] = addr[15 - 4*k -: 4];
    if (wr) begin
      nib[n++] = wd[3:0];
      nib[n++] = wd[7:4];
    end
    nib[n++] = 4'hF;
    for (int i = 0; i < n; i++) begin
      check_pins($sformatf("drv%0d", i), (i == 0) ? 1'b0 : 1'b1, 1'b1, nib[i]);
      @(negedge clk);
    end
    check_pins("tar2", 1'b1, 1'b0, 4'hF);
    @(negedge clk);

    if (aborting) begin
      for (int i = 0; i < n_abort; i++) begin
        bus.lpc_ad_in = fin;
        @(negedge clk);
      end
      bus.lpc_ad_in = 4'hF;
`ifdef LPC_HOST_ABORT_EN
      for (int i = 0; i < 4; i++) begin
        check_pins($sformatf("abort%0d", i), 1'b0, 1'b1, 4'hF);
        @(negedge clk);
      end
      check_pins("abort_rel", 1'b1, 1'b0, 4'hF);
      @(negedge clk);
`endif
      check_eq("abort_resp_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end else begin
      for (int i = 0; i < n_wait; i++) begin
        bus.lpc_ad_in = wait_nib;
        @(negedge clk);
      end
      bus.lpc_ad_in = fin;
      @(negedge clk);
      if (!wr) begin
        bus.lpc_ad_in = rd[3:0];
        check_pins("rdata0", 1'b1, 1'b0, 4'hF);
        @(negedge clk);
        bus.lpc_ad_in = rd[7:4];
        @(negedge clk);
      end
      bus.lpc_ad_in = 4'hF;
      check_pins("tarend1", 1'b1, 1'b0, 4'hF);
      @(negedge clk);
      check_eq("tarend2_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.lpc_ad_in = 4'hF;

    #2 rst_n = 1'b0;
    @(negedge clk);
    check_pins("rst", 1'b1, 1'b0, 4'hF);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_resp_error", 32'(bus.resp_error), 32'd0);
    check_eq("rst_rdata", 32'(bus.resp_rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(bus.req_ready), 32'd1);

    run_txn(1'b0, 16'h0080, 8'h00, 0, 4'h6, 4'h0, 8'h5A);
    run_txn(1'b1, 16'h03F8, 8'hC3, 0, 4'h6, 4'h0, 8'h00);
    run_txn(1'b0, 16'h0080, 8'h00, 5, 4'h6, 4'h0, 8'h3C);
    run_txn(1'b1, 16'hBEEF, 8'h11, 3, 4'h5, 4'h0, 8'h00);
    run_txn(1'b0, 16'h0061, 8'h00, NOSYNC_LIMIT, 4'hF, 4'h0, 8'h96);
    run_txn(1'b0, 16'h0064, 8'h00, 0, 4'h6, 4'hF, 8'h00);
    run_txn(1'b1, 16'h0064, 8'h77, 0, 4'h6, 4'hF, 8'h00);
    run_txn(1'b0, 16'h1234, 8'h00, 0, 4'h6, 4'hA, 8'hA7);
    run_txn(1'b1, 16'h2E2F, 8'h42, 1, 4'h5, 4'h3, 8'h00);
    run_txn(1'b0, 16'h0070, 8'h00, SYNC_TIMEOUT, 4'h6, 4'h0, 8'hE1);
    run_txn(1'b0, 16'h0071, 8'h00, 0, 4'h6, 4'h6, 8'h00);

    // Reset during the address phase drops the cycle with no response
    wait_ready(ok);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0055;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_pins("midrst", 1'b1, 1'b0, 4'hF);
    check_eq("midrst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_pins("post_rst_idle", 1'b1, 1'b0, 4'hF);

    run_txn(1'b0, 16'h002E, 8'h00, 2, 4'h5, 4'h0, 8'h99);
    repeat (4) @(negedge clk);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
